// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: register offsets, receiver state encoding and baud divisor helper.
package uart_pkg;

   localparam logic [7:0] UART_CFG_OFFSET    = 8'h00;
   localparam logic [7:0] UART_DATA_OFFSET   = 8'h04;
   localparam logic [7:0] UART_INST_OFFSET   = 8'h08;
   localparam logic [7:0] UART_STATUS_OFFSET = 8'h0C;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Bit period in clocks minus one, so the counter runs 0..divisor.
   function automatic logic [31:0] baudDiv(input int unsigned sysClk, input int unsigned baud);
      return sysClk / baud - 32'd1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bus slave interface shared by the UART blocks: select/address/write data in, ready/read data out.
interface uart_rx_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  HSEL;
   logic [3:0]            HBE;
   logic                  HREADY;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic                  HWRITE;
   logic [31:0]           HRDATA;
   logic [31:0]           HWDATA;

   modport master (output HSEL, HBE, HADDR, HWRITE, HWDATA, input HREADY, HRDATA);
   modport slave  (input HSEL, HBE, HADDR, HWRITE, HWDATA, output HREADY, HRDATA);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with simultaneous push/pop; a push while full is only taken if a pop frees a slot.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clock,
   input  logic                         nRst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             data_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] memQ [DEPTH];
   logic [PTR_W-1:0] wrPtrQ, rdPtrQ;
   logic [CNT_W-1:0] countQ;
   logic             doPush, doPop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (countQ == CNT_W'(DEPTH));
   assign empty_o = (countQ == '0);
   assign count_o = countQ;
   assign data_o  = memQ[rdPtrQ];
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);

   always_ff @(posedge clock) begin
      if (!nRst) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) memQ[i] <= '0;
      end else begin
         if (doPush) begin
            memQ[wrPtrQ] <= data_i;
            wrPtrQ       <= nextPtr(wrPtrQ);
         end
         if (doPop) rdPtrQ <= nextPtr(rdPtrQ);
         if (doPush && !doPop)      countQ <= countQ + 1'b1;
         else if (!doPush && doPop) countQ <= countQ - 1'b1;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with sticky interrupt and overrun/framing flags.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned sys_clk    = 50000000,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic     clock,
   input  logic     nRst,
   uart_rx_if.slave bus,
   output logic     interrupt,
   input  logic     RX
);
   localparam logic [31:0] DIV_SLOW = baudDiv(sys_clk, 9600);
   localparam logic [31:0] DIV_FAST = baudDiv(sys_clk, 115200);

   logic        rxMetaQ, rxsQ;
   rx_state_t   stateQ;
   logic [31:0] cntQ;
   logic [2:0]  bitQ;
   logic [7:0]  shregQ;
   logic        pushQ, badStopQ;
   logic [2:0]  cfgQ;
   logic        overrunQ, framingQ, intQ;
   logic        hreadyQ;
   logic [31:0] hrdataQ, rdataD;
   logic [31:0] divSel, halfSel;
   logic [11:0] offset;
   logic        rdStb, wrStb, popD, clrInt, clrErr, busy, intSet;
   logic        bufValid, bufFull;
   logic [7:0]  bufByte;
   logic [2:0]  bufCount;
   logic        unusedBits;

   assign divSel     = cfgQ[1] ? DIV_FAST : DIV_SLOW;
   assign halfSel    = divSel >> 1;
   assign offset     = bus.HADDR[11:0];
   assign rdStb      = bus.HSEL && !bus.HWRITE;
   assign wrStb      = bus.HSEL && bus.HWRITE;
   assign popD       = rdStb && (offset == {4'h0, UART_DATA_OFFSET});
   assign clrInt     = wrStb && (offset == {4'h0, UART_INST_OFFSET}) && bus.HWDATA[1];
   assign clrErr     = wrStb && (offset == {4'h0, UART_INST_OFFSET}) && bus.HWDATA[2];
   assign busy       = (stateQ != RX_IDLE);
   assign intSet     = cfgQ[2] && pushQ && !bufFull;
   assign unusedBits = ^{bus.HBE, bus.HADDR[ADDR_WIDTH-1:12], bus.HWDATA[31:3]};

   assign bus.HREADY = hreadyQ;
   assign bus.HRDATA = hrdataQ;
   assign interrupt  = intQ;

   always_ff @(posedge clock) begin
      if (!nRst) begin
         rxMetaQ <= 1'b1;
         rxsQ    <= 1'b1;
      end else begin
         rxMetaQ <= RX;
         rxsQ    <= rxMetaQ;
      end
   end

   // Counter compares use >= so a divisor switched to a smaller value mid-count cannot stall the receiver.
   always_ff @(posedge clock) begin
      if (!nRst) begin
         stateQ   <= RX_IDLE;
         cntQ     <= '0;
         bitQ     <= '0;
         shregQ   <= '0;
         pushQ    <= 1'b0;
         badStopQ <= 1'b0;
      end else begin
         pushQ    <= 1'b0;
         badStopQ <= 1'b0;
         if (!cfgQ[0]) begin
            stateQ <= RX_IDLE;
         end else begin
            case (stateQ)
               RX_IDLE: begin
                  if (!rxsQ) begin
                     stateQ <= RX_START;
                     cntQ   <= '0;
                  end
               end
               RX_START: begin
                  if (cntQ >= halfSel) begin
                     cntQ   <= '0;
                     bitQ   <= '0;
                     stateQ <= rxsQ ? RX_IDLE : RX_DATA;
                  end else begin
                     cntQ <= cntQ + 32'd1;
                  end
               end
               RX_DATA: begin
                  if (cntQ >= divSel) begin
                     shregQ[bitQ] <= rxsQ;
                     cntQ         <= '0;
                     if (bitQ == 3'd7) stateQ <= RX_STOP;
                     else              bitQ   <= bitQ + 3'd1;
                  end else begin
                     cntQ <= cntQ + 32'd1;
                  end
               end
               RX_STOP: begin
                  if (cntQ >= divSel) begin
                     cntQ     <= '0;
                     stateQ   <= RX_IDLE;
                     pushQ    <= rxsQ;
                     badStopQ <= !rxsQ;
                  end else begin
                     cntQ <= cntQ + 32'd1;
                  end
               end
               default: stateQ <= RX_IDLE;
            endcase
         end
      end
   end

`ifdef UART_RX_FIFO_EN
   logic       fifoEmpty;
   logic [7:0] fifoHead;

   uart_rx_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo (
      .clock   (clock),
      .nRst    (nRst),
      .push_i  (pushQ),
      .pop_i   (popD),
      .data_i  (shregQ),
      .data_o  (fifoHead),
      .full_o  (bufFull),
      .empty_o (fifoEmpty),
      .count_o (bufCount)
   );

   assign bufValid = !fifoEmpty;
   assign bufByte  = fifoEmpty ? 8'h00 : fifoHead;
`else
   logic [7:0] byteQ;
   logic       validQ;

   // A pop in the same cycle as a push frees the register, so the new byte lands without overrun.
   always_ff @(posedge clock) begin
      if (!nRst) begin
         byteQ  <= '0;
         validQ <= 1'b0;
      end else if (pushQ && (!validQ || popD)) begin
         byteQ  <= shregQ;
         validQ <= 1'b1;
      end else if (popD) begin
         validQ <= 1'b0;
      end
   end

   assign bufValid = validQ;
   assign bufFull  = validQ;
   assign bufByte  = byteQ;
   assign bufCount = 3'd0;
`endif

   always_comb begin
      rdataD = '0;
      case (offset)
         {4'h0, UART_CFG_OFFSET}:    rdataD = {29'b0, cfgQ};
         {4'h0, UART_DATA_OFFSET}:   rdataD = {24'b0, bufByte};
         {4'h0, UART_STATUS_OFFSET}: rdataD = {25'b0, bufCount, framingQ, overrunQ, busy, bufValid};
         default:                    rdataD = '0;
      endcase
   end

   // Flag sets take priority over same-cycle clears.
   always_ff @(posedge clock) begin
      if (!nRst) begin
         hreadyQ  <= 1'b0;
         hrdataQ  <= '0;
         cfgQ     <= '0;
         overrunQ <= 1'b0;
         framingQ <= 1'b0;
         intQ     <= 1'b0;
      end else begin
         hreadyQ <= bus.HSEL;
         if (rdStb) hrdataQ <= rdataD;
         if (wrStb && (offset == {4'h0, UART_CFG_OFFSET})) cfgQ <= bus.HWDATA[2:0];
         if (intSet)      intQ <= 1'b1;
         else if (clrInt) intQ <= 1'b0;
         if (pushQ && bufFull && !popD) overrunQ <= 1'b1;
         else if (clrErr)               overrunQ <= 1'b0;
         if (badStopQ)    framingQ <= 1'b1;
         else if (clrErr) framingQ <= 1'b0;
      end
   end
endmodule
